axis_rr_packet_arbiter: RTL

- Two-input, packet-granular round-robin arbiter that shares one AXI-Stream sink (the 16-word packet FIFO's slave port) between two AXI-Stream producers.
- Holds a grant for a whole packet: until the beat carrying tlast is accepted, or until MAX_BEATS beats pass, whichever comes first.
- Counts forwarded packets per input for software/debug visibility.
- Sits directly upstream of the packet FIFO in the capture path.

---
 rtl/axis_rr_packet_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Two-input, packet-granular round-robin AXI-Stream arbiter.
// A grant covers one whole packet: it ends on the beat carrying tlast, or
// on the MAX_BEATS-th beat, where tlast is forced so the downstream packet
// FIFO never sees a packet longer than its depth. Forwarded packets are
// counted per input.
module axis_rr_packet_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_BEATS          = 16,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  // input 0
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  // input 1
  input  logic                              s01_axis_tvalid,
  output logic                              s01_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [(C_AXIS_TDATA_WIDTH/8)-1:0] s01_axis_tstrb,
  input  logic                              s01_axis_tlast,
  // shared output
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  // status
  output logic [1:0]                        grant,
  output logic [CNT_WIDTH-1:0]              pkt_cnt0,
  output logic [CNT_WIDTH-1:0]              pkt_cnt1
);

  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  // Encoding matches the one-hot grant output, so grant is the state itself.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  rr_last_q, rr_last_d;   // input served most recently
  logic [CNT_WIDTH-1:0]  pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt1_q, pkt_cnt1_d;
  logic                  beat;

  // Arbitration, pass-through muxing and release/counter next-state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    rr_last_d       = rr_last_q;
    pkt_cnt0_d      = pkt_cnt0_q;
    pkt_cnt1_d      = pkt_cnt1_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    m00_axis_tlast  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the input that was not served last wins.
        if (s00_axis_tvalid && s01_axis_tvalid) begin
          state_d = rr_last_q ? GRANT0 : GRANT1;
        end else if (s00_axis_tvalid) begin
          state_d = GRANT0;
        end else if (s01_axis_tvalid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        m00_axis_tlast  = s00_axis_tlast || (beat_cnt_q == LAST_BEAT);
        s00_axis_tready = m00_axis_tready;
      end
      GRANT1: begin
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        m00_axis_tlast  = s01_axis_tlast || (beat_cnt_q == LAST_BEAT);
        s01_axis_tready = m00_axis_tready;
      end
      default: state_d = IDLE;
    endcase

    beat = m00_axis_tvalid && m00_axis_tready;

    // The releasing beat always returns to IDLE, which enforces the idle
    // cycle between consecutive grants.
    if (beat) begin
      if (m00_axis_tlast) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        rr_last_d  = (state_q == GRANT1);
        if (state_q == GRANT0) begin
          pkt_cnt0_d = pkt_cnt0_q + 1'b1;
        end else begin
          pkt_cnt1_d = pkt_cnt1_q + 1'b1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // State, beat counter, round-robin pointer and packet counters.
  always_ff @(posedge axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!axis_aresetn) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rr_last_q  <= 1'b1;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_last_q  <= rr_last_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign grant    = state_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
